// File: rtl/ram_share_arbiter_if.sv
// ram_share_arbiter_if: requester and RAM-side bus bundle for ram_share_arbiter
// Ports (slave = arbiter side):
//   REQ_OE_n/REQ_WE_n/REQ_ADDR/REQ_DIN in, REQ_GNT/REQ_DOUT out  - packed per-requester bus
//   RAM_ADDR/RAM_DIN/RAM_WE_n/RAM_OE_n/RAM_RFSH_n out, RAM_DOUT in - shared RAM port
//   RFSH_n in (MSX refresh), ARB_ERR out (sticky watchdog error)
interface ram_share_arbiter_if #(
  parameter int REQ_COUNT      = 3,
  parameter int ADDR_BIT_WIDTH = 23
);
  logic [REQ_COUNT-1:0]                REQ_OE_n, REQ_WE_n, REQ_GNT;
  logic [REQ_COUNT*ADDR_BIT_WIDTH-1:0] REQ_ADDR;
  logic [REQ_COUNT*8-1:0]              REQ_DIN;
  logic [7:0]                          REQ_DOUT, RAM_DIN, RAM_DOUT;
  logic [ADDR_BIT_WIDTH-1:0]           RAM_ADDR;
  logic                                RFSH_n, RAM_WE_n, RAM_OE_n, RAM_RFSH_n, ARB_ERR;
  modport slave (
    input  REQ_OE_n, REQ_WE_n, REQ_ADDR, REQ_DIN, RFSH_n, RAM_DOUT,
    output REQ_GNT, REQ_DOUT, RAM_ADDR, RAM_DIN, RAM_WE_n, RAM_OE_n, RAM_RFSH_n, ARB_ERR
  );
  modport master (
    output REQ_OE_n, REQ_WE_n, REQ_ADDR, REQ_DIN, RFSH_n, RAM_DOUT,
    input  REQ_GNT, REQ_DOUT, RAM_ADDR, RAM_DIN, RAM_WE_n, RAM_OE_n, RAM_RFSH_n, ARB_ERR
  );
endinterface

// File: rtl/ram_share_arbiter.sv
// ram_share_arbiter: shares one byte-wide RAM port between REQ_COUNT requesters
// Ports: CLK, RESET_n (async active-low), bus (ram_share_arbiter_if.slave).
// Requester 0 has fixed top priority, the rest are served round-robin; grants are
// registered, non-preemptive and separated by one strobe-idle GAP cycle.
// Optional watchdog: define RAM_SHARE_ARB_TIMEOUT_EN to bound a grant to TIMEOUT_CYCLES.
module ram_share_arbiter #(
  parameter int REQ_COUNT      = 3,
  parameter int ADDR_BIT_WIDTH = 23,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               CLK,
  input logic               RESET_n,
  ram_share_arbiter_if.slave bus
);
  localparam int IW = $clog2(REQ_COUNT);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t                    state_q, state_d;
  logic [IW-1:0]             owner_q, owner_d, rr_q, rr_d, win, idx, sel;
  logic [REQ_COUNT-1:0]      gnt_q, gnt_d, req, elig, blk;
  logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                din_q, din_d;
  logic                      we_n_q, we_n_d, oe_n_q, oe_n_d, rfsh_q, rfsh_d;
  logic                      found, drive, tmo;
  // Winner: requester 0 first, then the first eligible index at or after rr_q in 1..N-1.
  always_comb begin
    req   = ~(bus.REQ_OE_n & bus.REQ_WE_n);
    elig  = req & ~blk;
    found = elig[0];
    win   = '0;
    idx   = '0;
    for (int k = 0; k < REQ_COUNT - 1; k++) begin
      idx = IW'((int'(rr_q) - 1 + k) % (REQ_COUNT - 1) + 1);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    drive   = 1'b0;
    sel     = state_q == IDLE ? win : owner_q;
    rfsh_d  = bus.RFSH_n;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        owner_d = win;
        gnt_d   = REQ_COUNT'(1) << win;
        drive   = 1'b1;
      end
      GRANT: if (!req[owner_q] || tmo) begin
        state_d = GAP;
        gnt_d   = '0;
        if (owner_q != '0) rr_d = int'(owner_q) == REQ_COUNT - 1 ? IW'(1) : owner_q + 1'b1;
      end else drive = 1'b1;
      default: state_d = IDLE;
    endcase
    addr_d = drive ? bus.REQ_ADDR[sel*ADDR_BIT_WIDTH +: ADDR_BIT_WIDTH] : '0;
    din_d  = drive ? bus.REQ_DIN[sel*8 +: 8] : '0;
    we_n_d = drive ? bus.REQ_WE_n[sel] : 1'b1;
    // Both strobes low is a write, so the read strobe is suppressed.
    oe_n_d = drive ? bus.REQ_OE_n[sel] | ~bus.REQ_WE_n[sel] : 1'b1;
  end
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= IW'(1);
      gnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      rfsh_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      rfsh_q  <= rfsh_d;
    end
  end
`ifdef RAM_SHARE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [REQ_COUNT-1:0] blk_q, blk_d;
  // cnt_q holds the number of completed GRANT cycles; the TIMEOUT_CYCLES-th one forces GAP.
  assign tmo = state_q == GRANT && req[owner_q] && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    cnt_d = state_q == GRANT ? cnt_q + 1'b1 : '0;
    err_d = err_q | tmo;
    // A timed-out owner stays ineligible until it drops both strobes.
    blk_d = (blk_q & req) | (tmo ? gnt_q : '0);
  end
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      blk_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      blk_q <= blk_d;
    end
  end
  assign blk         = blk_q;
  assign bus.ARB_ERR = err_q;
`else
  assign tmo         = 1'b0;
  assign blk         = '0;
  // Constant 0; written against the parameter so it stays referenced in this build.
  assign bus.ARB_ERR = TIMEOUT_CYCLES < 0;
`endif
  assign bus.REQ_GNT    = gnt_q;
  assign bus.REQ_DOUT   = |gnt_q ? bus.RAM_DOUT : 8'h00;
  assign bus.RAM_ADDR   = addr_q;
  assign bus.RAM_DIN    = din_q;
  assign bus.RAM_WE_n   = we_n_q;
  assign bus.RAM_OE_n   = oe_n_q;
  assign bus.RAM_RFSH_n = rfsh_q;
endmodule

// File: tb/tb_ram_share_arbiter.sv
// tb_ram_share_arbiter: directed and random checks of ram_share_arbiter against a behavioural model
module tb_ram_share_arbiter;
  localparam int N  = 3;
  localparam int AW = 23;
  localparam int TO = 16;
`ifdef RAM_SHARE_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  always #5 CLK = ~CLK;
  ram_share_arbiter_if #(.REQ_COUNT(N), .ADDR_BIT_WIDTH(AW)) bus ();
  ram_share_arbiter #(.REQ_COUNT(N), .ADDR_BIT_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .bus(bus.slave)
  );
  int checks = 0;
  int errors = 0;
  // Reference model: owner (-1 = none), pending gap cycle, RR pointer, grant age, blocked set.
  int            m_owner, m_gap, m_rr, m_age;
  bit [N-1:0]    m_blk;
  logic [N-1:0]  e_gnt;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_din;
  logic          e_we, e_oe, e_rfsh, e_err;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(int i, logic oe_n, logic we_n, logic [AW-1:0] a, logic [7:0] d);
    bus.REQ_OE_n[i] = oe_n;
    bus.REQ_WE_n[i] = we_n;
    bus.REQ_ADDR[i*AW +: AW] = a;
    bus.REQ_DIN[i*8 +: 8] = d;
  endtask
  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_rr = 1; m_age = 0; m_blk = '0;
    e_gnt = '0; e_addr = '0; e_din = '0; e_we = 1'b1; e_oe = 1'b1; e_rfsh = 1'b1; e_err = 1'b0;
  endtask
  task automatic model_step();
    bit [N-1:0] rq, el;
    int w;
    rq = ~(bus.REQ_OE_n & bus.REQ_WE_n);
    e_rfsh = bus.RFSH_n;
    m_blk &= rq;
    if (m_owner >= 0) begin
      m_age++;
      if (!rq[m_owner] || (TMO && m_age == TO)) begin
        if (rq[m_owner]) begin e_err = 1'b1; m_blk[m_owner] = 1'b1; end
        if (m_owner > 0) m_rr = (m_owner + 1 == N) ? 1 : m_owner + 1;
        m_owner = -1;
        m_gap = 1;
      end
    end else if (m_gap != 0) m_gap = 0;
    else begin
      el = rq & ~m_blk;
      w = -1;
      if (el[0]) w = 0;
      for (int i = m_rr; i < N && w < 0; i++) if (el[i]) w = i;
      for (int i = 1; i < m_rr && w < 0; i++) if (el[i]) w = i;
      m_owner = w;
      m_age = 0;
    end
    e_gnt = '0; e_addr = '0; e_din = '0; e_we = 1'b1; e_oe = 1'b1;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_addr = bus.REQ_ADDR[m_owner*AW +: AW];
      e_din  = bus.REQ_DIN[m_owner*8 +: 8];
      e_we   = bus.REQ_WE_n[m_owner];
      e_oe   = bus.REQ_WE_n[m_owner] ? bus.REQ_OE_n[m_owner] : 1'b1;
    end
  endtask
  task automatic check_all(string t);
    chk({t, "/gnt"}, 64'(bus.REQ_GNT), 64'(e_gnt));
    chk({t, "/addr"}, 64'(bus.RAM_ADDR), 64'(e_addr));
    chk({t, "/din"}, 64'(bus.RAM_DIN), 64'(e_din));
    chk({t, "/we_n"}, 64'(bus.RAM_WE_n), 64'(e_we));
    chk({t, "/oe_n"}, 64'(bus.RAM_OE_n), 64'(e_oe));
    chk({t, "/rfsh_n"}, 64'(bus.RAM_RFSH_n), 64'(e_rfsh));
    chk({t, "/dout"}, 64'(bus.REQ_DOUT), 64'(|e_gnt ? bus.RAM_DOUT : 8'h00));
    chk({t, "/err"}, 64'(bus.ARB_ERR), 64'(e_err));
  endtask
  task automatic tick(string t);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all(t);
  endtask
  task automatic check_rst(string t);
    chk({t, "/gnt"}, 64'(bus.REQ_GNT), 64'(0));
    chk({t, "/addr"}, 64'(bus.RAM_ADDR), 64'(0));
    chk({t, "/din"}, 64'(bus.RAM_DIN), 64'(0));
    chk({t, "/we_n"}, 64'(bus.RAM_WE_n), 64'(1));
    chk({t, "/oe_n"}, 64'(bus.RAM_OE_n), 64'(1));
    chk({t, "/rfsh_n"}, 64'(bus.RAM_RFSH_n), 64'(1));
    chk({t, "/err"}, 64'(bus.ARB_ERR), 64'(0));
  endtask
  function automatic int owner_of(logic [N-1:0] g);
    return g[2] ? 2 : g[1] ? 1 : g[0] ? 0 : -1;
  endfunction
  initial begin
    int w, n1, n2;
    int exp_seq[4] = '{2, 1, 2, 1};
    logic [1:0] mode [N];
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, '0, '0);
    bus.RFSH_n = 1'b1;
    bus.RAM_DOUT = 8'h00;
    model_reset();
    repeat (2) @(negedge CLK);
    check_rst("reset");
    RESET_n = 1'b1;
    tick("idle");
    // Requester 1 read
    set_req(1, 1'b0, 1'b1, 23'h001234, 8'h00);
    bus.RAM_DOUT = 8'h5A;
    tick("rd1");
    chk("rd1_gnt", 64'(bus.REQ_GNT), 64'(3'b010));
    chk("rd1_oe", 64'(bus.RAM_OE_n), 64'(0));
    chk("rd1_addr", 64'(bus.RAM_ADDR), 64'(23'h001234));
    chk("rd1_dout", 64'(bus.REQ_DOUT), 64'(8'h5A));
    set_req(1, 1'b1, 1'b1, '0, '0);
    tick("rel1");
    tick("rel1_idle");
    // Requesters 0 and 2 together: 0 first, then 2 after GAP
    set_req(0, 1'b0, 1'b1, 23'h000100, 8'h00);
    set_req(2, 1'b0, 1'b1, 23'h000200, 8'h00);
    tick("pri");
    chk("pri_gnt0", 64'(bus.REQ_GNT), 64'(3'b001));
    tick("pri_hold");
    set_req(0, 1'b1, 1'b1, '0, '0);
    tick("pri_gap");
    chk("pri_gap_gnt", 64'(bus.REQ_GNT), 64'(0));
    tick("pri_idle");
    tick("pri_g2");
    chk("pri_gnt2", 64'(bus.REQ_GNT), 64'(3'b100));
    set_req(2, 1'b1, 1'b1, '0, '0);
    tick("rel2");
    tick("rel2_idle");
    // No preemption of requester 1 by requester 0
    set_req(1, 1'b0, 1'b1, 23'h000300, 8'h00);
    tick("np_g1");
    set_req(0, 1'b0, 1'b1, 23'h000400, 8'h00);
    tick("np_h1");
    tick("np_h2");
    chk("np_hold", 64'(bus.REQ_GNT), 64'(3'b010));
    set_req(1, 1'b1, 1'b1, '0, '0);
    tick("np_gap");
    tick("np_idle");
    chk("np_wait", 64'(bus.REQ_GNT), 64'(0));
    tick("np_g0");
    chk("np_gnt0", 64'(bus.REQ_GNT), 64'(3'b001));
    set_req(0, 1'b1, 1'b1, '0, '0);
    tick("np_rel");
    tick("np_rel_idle");
    // Round-robin between 1 and 2 with continuous re-requests
    set_req(1, 1'b0, 1'b1, 23'h000011, 8'h00);
    set_req(2, 1'b0, 1'b1, 23'h000022, 8'h00);
    for (int n = 0; n < 4; n++) begin
      w = -1;
      for (int c = 0; c < 6 && w < 0; c++) begin
        tick("rr_wait");
        w = owner_of(bus.REQ_GNT);
      end
      chk("rr_owner", 64'(w), 64'(exp_seq[n]));
      tick("rr_hold");
      if (w > 0) set_req(w, 1'b1, 1'b1, '0, '0);
      tick("rr_gap");
      chk("rr_gap_oe", 64'(bus.RAM_OE_n), 64'(1));
      chk("rr_gap_we", 64'(bus.RAM_WE_n), 64'(1));
      if (w > 0) set_req(w, 1'b0, 1'b1, AW'(w * 17), 8'h00);
    end
    set_req(1, 1'b1, 1'b1, '0, '0);
    set_req(2, 1'b1, 1'b1, '0, '0);
    repeat (3) tick("rr_end");
    // Requester 2 write, then reset mid-grant
    set_req(2, 1'b0, 1'b0, 23'h7FFFFF, 8'hA5);
    tick("wr2");
    chk("wr2_we", 64'(bus.RAM_WE_n), 64'(0));
    chk("wr2_oe", 64'(bus.RAM_OE_n), 64'(1));
    chk("wr2_din", 64'(bus.RAM_DIN), 64'(8'hA5));
    chk("wr2_addr", 64'(bus.RAM_ADDR), 64'(23'h7FFFFF));
    tick("wr2_hold");
    #2 RESET_n = 1'b0;
    #1 check_rst("midrst");
    model_reset();
    @(negedge CLK);
    set_req(2, 1'b1, 1'b1, '0, '0);
    RESET_n = 1'b1;
    tick("after_rst");
    // Random traffic with address changes, vanishing requests and refresh toggling
    for (int i = 0; i < N; i++) mode[i] = 2'd3;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) mode[i] = 2'($urandom_range(0, 3));
        set_req(i, mode[i][0], mode[i][1], AW'($urandom), 8'($urandom));
      end
      bus.RFSH_n = 1'($urandom);
      bus.RAM_DOUT = 8'($urandom);
      tick("rand");
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, '0, '0);
    repeat (3) tick("rand_end");
`ifdef RAM_SHARE_ARB_TIMEOUT_EN
    // Watchdog: requester 1 holds for 40 cycles while requester 2 waits
    set_req(1, 1'b0, 1'b1, 23'h000555, 8'h00);
    tick("to_g1");
    chk("to_first", 64'(bus.REQ_GNT), 64'(3'b010));
    set_req(2, 1'b0, 1'b1, 23'h000666, 8'h00);
    n1 = 1;
    n2 = 0;
    for (int c = 0; c < 40; c++) begin
      tick("to");
      if (bus.REQ_GNT == 3'b010) n1++;
      if (bus.REQ_GNT == 3'b100) begin
        n2++;
        if (n2 == 5) set_req(2, 1'b1, 1'b1, '0, '0);
      end
    end
    chk("to_g1_cycles", 64'(n1), 64'(TO));
    chk("to_g2_cycles", 64'(n2), 64'(5));
    chk("to_err", 64'(bus.ARB_ERR), 64'(1));
    set_req(1, 1'b1, 1'b1, '0, '0);
    tick("to_drop");
    set_req(1, 1'b0, 1'b1, 23'h000777, 8'h00);
    w = -1;
    for (int c = 0; c < 6 && w < 0; c++) begin
      tick("to_regrant");
      w = owner_of(bus.REQ_GNT);
    end
    chk("to_regrant1", 64'(w), 64'(1));
    set_req(1, 1'b1, 1'b1, '0, '0);
    repeat (3) tick("to_end");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
